// File: rtl/ahb_slave_mem.sv
// rtl/ahb_slave_mem.sv - AHB-Lite word-organised memory slave with wait states and two-cycle ERROR response
//
// Ports:
//   HCLK       in   clock, all state updates on the rising edge
//   HRESET     in   synchronous active-high reset
//   HSEL       in   slave select from the address decoder
//   HADDR      in   byte address (address phase)
//   HTRANS     in   transfer type: 0=IDLE 1=BUSY 2=NONSEQ 3=SEQ
//   HWRITE     in   1=write 0=read (address phase)
//   HSIZE      in   0=byte 1=halfword 2=word, others illegal
//   HWDATA     in   write data (data phase)
//   HREADY     in   bus-level ready from the response mux
//   HRDATA     out  read data, zero outside a read data phase
//   HREADYOUT  out  slave ready
//   HRESP      out  0=OKAY 1=ERROR
module ahb_slave_mem #(
    parameter int MEM_DEPTH   = 256,
    parameter int WAIT_STATES = 0
) (
    input  logic        HCLK,
    input  logic        HRESET,
    input  logic        HSEL,
    input  logic [31:0] HADDR,
    input  logic [1:0]  HTRANS,
    input  logic        HWRITE,
    input  logic [2:0]  HSIZE,
    input  logic [31:0] HWDATA,
    input  logic        HREADY,
    output logic [31:0] HRDATA,
    output logic        HREADYOUT,
    output logic        HRESP
);

    localparam int AW = $clog2(MEM_DEPTH);
    localparam logic [3:0] CNT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_DATA,
        S_ERR1,
        S_ERR2
    } state_t;

    logic [31:0]   mem [MEM_DEPTH];

    state_t        state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic [AW-1:0] waddr_q, waddr_d;
    logic [3:0]    be_q, be_d;
    logic          write_q, write_d;

    logic          accept;
    logic          start;
    logic          legal;
    logic [3:0]    lanes;

    // Only HTRANS[1] distinguishes active (NONSEQ/SEQ) from IDLE/BUSY.
    logic          unused_htrans0;
    assign unused_htrans0 = HTRANS[0];

    assign accept = HSEL & HREADY & HTRANS[1];
    // WAIT and ERR1 hold HREADYOUT low, so no new address phase can land there.
    assign start  = accept & ((state_q == S_IDLE) | (state_q == S_DATA) | (state_q == S_ERR2));

    // Address-phase legality and little-endian byte-lane enables.
    always_comb begin
        legal = 1'b1;
        if (HSIZE > 3'd2)                           legal = 1'b0;
        if ((HSIZE == 3'd1) && HADDR[0])            legal = 1'b0;
        if ((HSIZE == 3'd2) && (HADDR[1:0] != 2'b00)) legal = 1'b0;
        // Full upper-address compare so out-of-range addresses never alias.
        if (HADDR[31:2] >= 30'(MEM_DEPTH))          legal = 1'b0;

        case (HSIZE)
            3'd0:    lanes = 4'b0001 << HADDR[1:0];
            3'd1:    lanes = HADDR[1] ? 4'b1100 : 4'b0011;
            default: lanes = 4'b1111;
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        waddr_d = waddr_q;
        be_d    = be_q;
        write_d = write_q;

        case (state_q)
            S_WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = S_DATA;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_ERR1:  state_d = S_ERR2;
            default: state_d = S_IDLE;  // IDLE, DATA, ERR2 without a new transfer
        endcase

        if (start) begin
            waddr_d = HADDR[AW+1:2];
            be_d    = lanes;
            write_d = HWRITE;
            if (!legal) begin
                state_d = S_ERR1;
            end else if (WAIT_STATES > 0) begin
                state_d = S_WAIT;
                cnt_d   = CNT_LOAD;
            end else begin
                state_d = S_DATA;
            end
        end
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            waddr_q <= '0;
            be_q    <= '0;
            write_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            waddr_q <= waddr_d;
            be_q    <= be_d;
            write_q <= write_d;
        end
    end

    // Memory is never cleared; a reset edge simply suppresses the pending write.
    always_ff @(posedge HCLK) begin
        if (!HRESET && (state_q == S_DATA) && write_q) begin
            for (int b = 0; b < 4; b++) begin
                if (be_q[b]) begin
                    mem[waddr_q][8*b +: 8] <= HWDATA[8*b +: 8];
                end
            end
        end
    end

    // Asynchronous array read: a read pipelined behind a write to the same
    // word sees the value committed on the edge that started its data phase.
    always_comb begin
        HRDATA    = ((state_q == S_DATA) && !write_q) ? mem[waddr_q] : 32'd0;
        HREADYOUT = !((state_q == S_WAIT) || (state_q == S_ERR1));
        HRESP     = (state_q == S_ERR1) || (state_q == S_ERR2);
    end

endmodule

// File: tb/tb_ahb_slave_mem.sv
// tb/tb_ahb_slave_mem.sv - directed self-checking bench for ahb_slave_mem (zero and three wait states)
module tb_ahb_slave_mem;

    logic        clk = 1'b0;
    logic        hreset [2];
    logic        hsel [2];
    logic [31:0] haddr [2];
    logic [1:0]  htrans [2];
    logic        hwrite [2];
    logic [2:0]  hsize [2];
    logic [31:0] hwdata [2];
    logic        hready [2];
    logic [31:0] hrdata [2];
    logic        hreadyout [2];
    logic        hresp [2];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    assign hready[0] = hreadyout[0];
    assign hready[1] = hreadyout[1];

    ahb_slave_mem #(.MEM_DEPTH(256), .WAIT_STATES(0)) u_dut0 (
        .HCLK(clk), .HRESET(hreset[0]), .HSEL(hsel[0]), .HADDR(haddr[0]),
        .HTRANS(htrans[0]), .HWRITE(hwrite[0]), .HSIZE(hsize[0]), .HWDATA(hwdata[0]),
        .HREADY(hready[0]), .HRDATA(hrdata[0]), .HREADYOUT(hreadyout[0]), .HRESP(hresp[0])
    );

    ahb_slave_mem #(.MEM_DEPTH(256), .WAIT_STATES(3)) u_dut3 (
        .HCLK(clk), .HRESET(hreset[1]), .HSEL(hsel[1]), .HADDR(haddr[1]),
        .HTRANS(htrans[1]), .HWRITE(hwrite[1]), .HSIZE(hsize[1]), .HWDATA(hwdata[1]),
        .HREADY(hready[1]), .HRDATA(hrdata[1]), .HREADYOUT(hreadyout[1]), .HRESP(hresp[1])
    );

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    task automatic drive(input int d, input logic sel, input logic [1:0] trans, input logic wr,
                         input logic [2:0] sz, input logic [31:0] addr);
        hsel[d]   = sel;
        htrans[d] = trans;
        hwrite[d] = wr;
        hsize[d]  = sz;
        haddr[d]  = addr;
    endtask

    task automatic idle(input int d);
        drive(d, 1'b0, 2'd0, 1'b0, 3'd0, 32'd0);
    endtask

    task automatic chk_resp(input string tag, input int d, input logic rdy, input logic rsp);
        check_eq({tag, "_hreadyout"}, {31'd0, hreadyout[d]}, {31'd0, rdy});
        check_eq({tag, "_hresp"}, {31'd0, hresp[d]}, {31'd0, rsp});
    endtask

    // Single transfer from an idle bus; counts low HREADYOUT cycles (bounded).
    task automatic xfer(input string tag, input int d, input logic wr, input logic [2:0] sz,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] exp_rdata, input int exp_waits);
        int waits;
        drive(d, 1'b1, 2'd2, wr, sz, addr);
        @(negedge clk);
        idle(d);
        hwdata[d] = wdata;
        waits = 0;
        while (hreadyout[d] !== 1'b1 && waits < 40) begin
            check_eq({tag, "_wait_hresp"}, {31'd0, hresp[d]}, 32'd0);
            waits++;
            @(negedge clk);
        end
        check_eq({tag, "_waits"}, waits, exp_waits);
        check_eq({tag, "_hresp"}, {31'd0, hresp[d]}, 32'd0);
        if (!wr) check_eq({tag, "_hrdata"}, hrdata[d], exp_rdata);
        @(negedge clk);
    endtask

    // Illegal transfer from an idle bus: ERR1, ERR2, then back to idle OKAY.
    task automatic err_seq(input string tag, input int d, input logic wr, input logic [2:0] sz,
                           input logic [31:0] addr);
        drive(d, 1'b1, 2'd2, wr, sz, addr);
        @(negedge clk);
        idle(d);
        hwdata[d] = 32'hFFFF_FFFF;
        chk_resp({tag, "_err1"}, d, 1'b0, 1'b1);
        @(negedge clk);
        chk_resp({tag, "_err2"}, d, 1'b1, 1'b1);
        check_eq({tag, "_err2_hrdata"}, hrdata[d], 32'd0);
        @(negedge clk);
        chk_resp({tag, "_idle"}, d, 1'b1, 1'b0);
    endtask

    initial begin
        for (int i = 0; i < 2; i++) begin
            hreset[i] = 1'b1;
            hwdata[i] = 32'd0;
            idle(i);
        end
        repeat (2) @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            chk_resp("reset", i, 1'b1, 1'b0);
            check_eq("reset_hrdata", hrdata[i], 32'd0);
            hreset[i] = 1'b0;
        end

        // Back-to-back word write then read, accepted on the first edge out of reset.
        drive(0, 1'b1, 2'd2, 1'b1, 3'd2, 32'h10);
        @(negedge clk);
        chk_resp("b2b_wr", 0, 1'b1, 1'b0);
        hwdata[0] = 32'hDEAD_BEEF;
        drive(0, 1'b1, 2'd2, 1'b0, 3'd2, 32'h10);
        @(negedge clk);
        chk_resp("b2b_rd", 0, 1'b1, 1'b0);
        check_eq("b2b_rd_hrdata", hrdata[0], 32'hDEAD_BEEF);
        idle(0);
        @(negedge clk);
        check_eq("b2b_idle_hrdata", hrdata[0], 32'd0);

        // Byte-lane writes.
        xfer("wr_word", 0, 1'b1, 3'd2, 32'h10, 32'h1122_3344, 32'd0, 0);
        xfer("wr_b3",   0, 1'b1, 3'd0, 32'h13, 32'hAAAA_AAAA, 32'd0, 0);
        xfer("rd_b3",   0, 1'b0, 3'd2, 32'h10, 32'd0, 32'hAA22_3344, 0);
        xfer("wr_h1",   0, 1'b1, 3'd1, 32'h12, 32'h5566_9999, 32'd0, 0);
        xfer("rd_h1",   0, 1'b0, 3'd2, 32'h10, 32'd0, 32'h5566_3344, 0);
        xfer("wr_b1",   0, 1'b1, 3'd0, 32'h11, 32'h0000_BB00, 32'd0, 0);
        xfer("rd_b1",   0, 1'b0, 3'd2, 32'h10, 32'd0, 32'h5566_BB44, 0);

        // BUSY with HSEL=1, then NONSEQ with HSEL=0: neither is a transfer.
        drive(0, 1'b1, 2'd1, 1'b1, 3'd2, 32'h10);
        hwdata[0] = 32'h0;
        @(negedge clk);
        chk_resp("busy", 0, 1'b1, 1'b0);
        drive(0, 1'b0, 2'd2, 1'b1, 3'd2, 32'h10);
        @(negedge clk);
        chk_resp("nosel", 0, 1'b1, 1'b0);
        idle(0);
        @(negedge clk);
        xfer("rd_nochg", 0, 1'b0, 3'd2, 32'h10, 32'd0, 32'h5566_BB44, 0);

        // Error responses; none may touch memory or alias.
        xfer("wr_w0", 0, 1'b1, 3'd2, 32'h0, 32'h0102_0304, 32'd0, 0);
        err_seq("e_unalign_w", 0, 1'b0, 3'd2, 32'h2);
        err_seq("e_range",     0, 1'b1, 3'd2, 32'h400);
        err_seq("e_size3",     0, 1'b1, 3'd3, 32'h10);
        err_seq("e_unalign_h", 0, 1'b1, 3'd1, 32'h11);

        // New transfer accepted during ERR2 is handled normally.
        drive(0, 1'b1, 2'd2, 1'b0, 3'd2, 32'h2);
        @(negedge clk);
        chk_resp("e2p_err1", 0, 1'b0, 1'b1);
        idle(0);
        @(negedge clk);
        chk_resp("e2p_err2", 0, 1'b1, 1'b1);
        drive(0, 1'b1, 2'd2, 1'b0, 3'd2, 32'h0);
        @(negedge clk);
        chk_resp("e2p_data", 0, 1'b1, 1'b0);
        check_eq("e2p_hrdata", hrdata[0], 32'h0102_0304);
        idle(0);
        @(negedge clk);
        xfer("rd_after_err", 0, 1'b0, 3'd2, 32'h10, 32'd0, 32'h5566_BB44, 0);

        // Three wait states.
        xfer("ws3_wr", 1, 1'b1, 3'd2, 32'h0, 32'hCAFE_F00D, 32'd0, 3);
        xfer("ws3_rd", 1, 1'b0, 3'd2, 32'h0, 32'd0, 32'hCAFE_F00D, 3);

        // Reset during WAIT of a write aborts it.
        drive(1, 1'b1, 2'd2, 1'b1, 3'd2, 32'h0);
        hwdata[1] = 32'h1234_5678;
        @(negedge clk);
        chk_resp("rst_wait", 1, 1'b0, 1'b0);
        idle(1);
        hreset[1] = 1'b1;
        @(negedge clk);
        chk_resp("rst_abort", 1, 1'b1, 1'b0);
        check_eq("rst_abort_hrdata", hrdata[1], 32'd0);
        hreset[1] = 1'b0;
        xfer("ws3_rd_old", 1, 1'b0, 3'd2, 32'h0, 32'd0, 32'hCAFE_F00D, 3);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ahb_slave_mem.md
AHB_SLAVE_MEM -- requirements
Module: ahb_slave_mem

Interface
- REQ-001: Parameter MEM_DEPTH, default 256, size of the backing store in 32-bit words (power of two).
- REQ-002: Parameter WAIT_STATES, default 0, range 0-15; extra data-phase cycles inserted per OKAY transfer.
- REQ-003: HCLK  in  1  sole clock; all state updates on its rising edge.
- REQ-004: HRESET  in  1  synchronous, active-high reset.
- REQ-005: HSEL  in  1  slave select from the address decoder.
- REQ-006: HADDR  in  32  byte address (address phase).
- REQ-007: HTRANS  in  2  0=IDLE, 1=BUSY, 2=NONSEQ, 3=SEQ.
- REQ-008: HWRITE  in  1  1=write, 0=read (address phase).
- REQ-009: HSIZE  in  3  0=byte, 1=halfword, 2=word; all other values are illegal.
- REQ-010: HWDATA  in  32  write data (data phase).
- REQ-011: HREADY  in  1  bus-level ready, returned from the response mux.
- REQ-012: HRDATA  out  32  read data.
- REQ-013: HREADYOUT  out  1  slave ready.
- REQ-014: HRESP  out  1  0=OKAY, 1=ERROR.
- REQ-015: HRDATA, HREADYOUT and HRESP SHALL be packable directly into the package Slave_t response struct with no glue logic.

Function
- REQ-016: A transfer SHALL be accepted only on an edge where HSEL=1, HREADY=1 and HTRANS[1]=1; on that edge HADDR, HWRITE and HSIZE are registered.
- REQ-017: IDLE/BUSY transfers, or cycles with HSEL=0, SHALL produce a zero-wait OKAY response (HREADYOUT=1, HRESP=0) and SHALL NOT modify memory.
- REQ-018: The FSM SHALL have the states IDLE, WAIT, DATA, ERR1 and ERR2.
- REQ-019: FSM transitions on an accepted legal transfer:
  - WAIT_STATES>0: go to WAIT and load the counter with WAIT_STATES-1.
  - WAIT_STATES=0: go to DATA.
- REQ-020: In WAIT, HREADYOUT SHALL be 0 and HRESP 0; the counter decrements each cycle; at 0 the FSM moves to DATA.
- REQ-021: In DATA, HREADYOUT SHALL be 1 and HRESP 0; the transfer completes on this edge.
- REQ-022: From DATA, a new accepted transfer on the same edge SHALL be pipelined with no idle cycle; otherwise the FSM returns to IDLE.
- REQ-023: A transfer SHALL be illegal if any of the following holds: HSIZE>2; HSIZE=1 with HADDR[0]=1; HSIZE=2 with HADDR[1:0]!=0; HADDR[31:2]>=MEM_DEPTH.
- REQ-024: An illegal transfer SHALL get the two-cycle ERROR response:
  - ERR1: HREADYOUT=0, HRESP=1.
  - ERR2: HREADYOUT=1, HRESP=1.
  - No wait states are inserted and memory is not written.
- REQ-025: A transfer accepted during ERR2 SHALL be handled normally; if HTRANS=IDLE is presented during ERR2, the FSM returns to IDLE.
- REQ-026: Writes SHALL update only the addressed byte lanes, little-endian:
  - byte: lane HADDR[1:0];
  - halfword: lanes HADDR[1]*2 and HADDR[1]*2+1;
  - word: all four lanes.
  - HWDATA is sampled on the completing edge of the DATA state.
- REQ-027: Reads SHALL drive the full 32-bit word at the registered word address on HRDATA in DATA; outside DATA, HRDATA SHALL be 0.
- REQ-028: A read whose address phase overlaps the data phase of a write to the same word SHALL return the newly written data.
- REQ-029: Address bits above log2(MEM_DEPTH)+1 SHALL NOT alias; an out-of-range address is an error per REQ-023.

Reset
- REQ-030: While HRESET=1, on each rising edge of HCLK:
  - FSM goes to IDLE and the wait counter clears;
  - HREADYOUT=1, HRESP=0, HRDATA=0;
  - registered address-phase signals clear.
- REQ-031: Reset asserted mid-transfer (WAIT, DATA, ERR1 or ERR2) SHALL abort the transfer with no memory write; memory contents are otherwise preserved and not initialised by reset.
- REQ-032: The first transfer SHALL be accepted on the first edge with HRESET=0.

Verification
- REQ-033: WAIT_STATES=0: word write 0xDEADBEEF @0x10, then read @0x10 back-to-back -> HREADYOUT held 1, read data phase HRDATA=0xDEADBEEF, HRESP=0.
- REQ-034: Byte write 0xAA @0x13 over existing 0x11223344 @0x10 -> read @0x10 returns 0xAA223344.
- REQ-035: WAIT_STATES=3: read @0x0 -> HREADYOUT low for exactly 3 cycles, then high with data and HRESP=0.
- REQ-036: Word read @0x2, then write @MEM_DEPTH*4 -> each gets ERR1 (HREADYOUT=0, HRESP=1) then ERR2 (HREADYOUT=1, HRESP=1); memory unchanged.
- REQ-037: HRESET asserted during WAIT of a write -> next cycle HREADYOUT=1, HRESP=0, HRDATA=0; a later read of that address shows the old value.
- REQ-038: HSEL=1, HTRANS=BUSY, and HSEL=0 with HTRANS=NONSEQ -> zero-wait OKAY, no memory change.
